// File: rtl/register_file_pkg.sv
// Shared widths, index/data types and boolean constants for the architectural
// register file and its read ports.
package register_file_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_IDX_W = 4;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [REG_IDX_W-1:0] reg_index_t;
  typedef logic [ROB_IDX_W-1:0] rob_index_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/register_file_reg_read_port.sv
// One decoder lookup port: reads committed state for a source register and
// forwards a same-cycle commit that retires the pending producer.
module register_file_reg_read_port
  import register_file_pkg::*;
#(
  parameter int P_DATA_W    = DATA_W,
  parameter int P_REG_NUM   = REG_NUM,
  parameter int P_REG_IDX_W = REG_IDX_W,
  parameter int P_ROB_IDX_W = ROB_IDX_W
) (
  input  logic [P_REG_IDX_W-1:0]                rs,
  input  logic [P_REG_NUM-1:0][P_DATA_W-1:0]    value_vec,
  input  logic [P_REG_NUM-1:0]                  busy_vec,
  input  logic [P_REG_NUM-1:0][P_ROB_IDX_W-1:0] tag_vec,
  input  logic                                  commit,
  input  logic [P_ROB_IDX_W-1:0]                commit_rob_index,
  input  logic [P_REG_IDX_W-1:0]                commit_index,
  input  logic [P_DATA_W-1:0]                   commit_val,
  output logic                                  busy,
  output logic [P_DATA_W-1:0]                   val,
  output logic [P_ROB_IDX_W-1:0]                tag
);

  logic bypass_s;

  // Lookup with commit forwarding; x0 always reads as an idle zero.
  always_comb begin
    bypass_s = commit && (rs == commit_index) && busy_vec[rs]
               && (tag_vec[rs] == commit_rob_index);
    busy = FALSE;
    val  = {P_DATA_W{1'b0}};
    tag  = {P_ROB_IDX_W{1'b0}};
    if (rs == {P_REG_IDX_W{1'b0}}) begin
      busy = FALSE;
    end else if (bypass_s) begin
      busy = FALSE;
      val  = commit_val;
      tag  = tag_vec[rs];
    end else begin
      busy = busy_vec[rs];
      val  = value_vec[rs];
      tag  = tag_vec[rs];
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags: takes in-order ROB commits,
// records decoder renames and serves two zero-latency source lookups.
module register_file
  import register_file_pkg::*;
#(
  parameter int P_DATA_W    = DATA_W,
  parameter int P_REG_NUM   = REG_NUM,
  parameter int P_REG_IDX_W = REG_IDX_W,
  parameter int P_ROB_IDX_W = ROB_IDX_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clr_in,
  input  logic                   rob_to_reg_commit,
  input  logic [P_ROB_IDX_W-1:0] rob_to_reg_rob_index,
  input  logic [P_REG_IDX_W-1:0] rob_to_reg_index,
  input  logic [P_DATA_W-1:0]    rob_to_reg_val,
  input  logic                   dc_to_reg_rename_ready,
  input  logic [P_REG_IDX_W-1:0] dc_to_reg_rd,
  input  logic [P_ROB_IDX_W-1:0] dc_to_reg_rename_index,
  input  logic [P_REG_IDX_W-1:0] dc_to_reg_rs1,
  input  logic [P_REG_IDX_W-1:0] dc_to_reg_rs2,
  output logic                   reg_to_dc_rs1_busy,
  output logic [P_DATA_W-1:0]    reg_to_dc_rs1_val,
  output logic [P_ROB_IDX_W-1:0] reg_to_dc_rs1_tag,
  output logic                   reg_to_dc_rs2_busy,
  output logic [P_DATA_W-1:0]    reg_to_dc_rs2_val,
  output logic [P_ROB_IDX_W-1:0] reg_to_dc_rs2_tag
);

  logic [P_REG_NUM-1:0][P_DATA_W-1:0]    value_r;
  logic [P_REG_NUM-1:0]                  busy_r;
  logic [P_REG_NUM-1:0][P_ROB_IDX_W-1:0] tag_r;

  // Commit/rename/flush update; entry 0 is never written so x0 stays zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      value_r <= {(P_REG_NUM*P_DATA_W){1'b0}};
      busy_r  <= {P_REG_NUM{1'b0}};
      tag_r   <= {(P_REG_NUM*P_ROB_IDX_W){1'b0}};
    end else if (rdy_in) begin
      for (int i = 1; i < P_REG_NUM; i++) begin
        if (rob_to_reg_commit && (rob_to_reg_index == P_REG_IDX_W'(i))) begin
          value_r[i] <= rob_to_reg_val;
        end
        // Flush beats rename, and rename beats the retiring commit's clear.
        if (clr_in) begin
          busy_r[i] <= FALSE;
        end else if (dc_to_reg_rename_ready && (dc_to_reg_rd == P_REG_IDX_W'(i))) begin
          busy_r[i] <= TRUE;
          tag_r[i]  <= dc_to_reg_rename_index;
        end else if (rob_to_reg_commit && (rob_to_reg_index == P_REG_IDX_W'(i))
                     && busy_r[i] && (tag_r[i] == rob_to_reg_rob_index)) begin
          busy_r[i] <= FALSE;
        end
      end
    end
  end

  register_file_reg_read_port #(
    .P_DATA_W(P_DATA_W), .P_REG_NUM(P_REG_NUM),
    .P_REG_IDX_W(P_REG_IDX_W), .P_ROB_IDX_W(P_ROB_IDX_W)
  ) u_rs1_port (
    .rs               (dc_to_reg_rs1),
    .value_vec        (value_r),
    .busy_vec         (busy_r),
    .tag_vec          (tag_r),
    .commit           (rob_to_reg_commit),
    .commit_rob_index (rob_to_reg_rob_index),
    .commit_index     (rob_to_reg_index),
    .commit_val       (rob_to_reg_val),
    .busy             (reg_to_dc_rs1_busy),
    .val              (reg_to_dc_rs1_val),
    .tag              (reg_to_dc_rs1_tag)
  );

  register_file_reg_read_port #(
    .P_DATA_W(P_DATA_W), .P_REG_NUM(P_REG_NUM),
    .P_REG_IDX_W(P_REG_IDX_W), .P_ROB_IDX_W(P_ROB_IDX_W)
  ) u_rs2_port (
    .rs               (dc_to_reg_rs2),
    .value_vec        (value_r),
    .busy_vec         (busy_r),
    .tag_vec          (tag_r),
    .commit           (rob_to_reg_commit),
    .commit_rob_index (rob_to_reg_rob_index),
    .commit_index     (rob_to_reg_index),
    .commit_val       (rob_to_reg_val),
    .busy             (reg_to_dc_rs2_busy),
    .val              (reg_to_dc_rs2_val),
    .tag              (reg_to_dc_rs2_tag)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios with literal
// expectations plus randomized traffic against an array-based reference model.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic        commit;
  logic [3:0]  c_rob;
  logic [4:0]  c_idx;
  logic [31:0] c_val;
  logic        ren;
  logic [4:0]  rd;
  logic [3:0]  ren_idx;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic [31:0] rs1_val;
  logic [3:0]  rs1_tag;
  logic        rs2_busy;
  logic [31:0] rs2_val;
  logic [3:0]  rs2_tag;

  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];

  int total = 0;
  int bad   = 0;

  register_file dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .clr_in                 (clr_in),
    .rob_to_reg_commit      (commit),
    .rob_to_reg_rob_index   (c_rob),
    .rob_to_reg_index       (c_idx),
    .rob_to_reg_val         (c_val),
    .dc_to_reg_rename_ready (ren),
    .dc_to_reg_rd           (rd),
    .dc_to_reg_rename_index (ren_idx),
    .dc_to_reg_rs1          (rs1),
    .dc_to_reg_rs2          (rs2),
    .reg_to_dc_rs1_busy     (rs1_busy),
    .reg_to_dc_rs1_val      (rs1_val),
    .reg_to_dc_rs1_tag      (rs1_tag),
    .reg_to_dc_rs2_busy     (rs2_busy),
    .reg_to_dc_rs2_val      (rs2_val),
    .reg_to_dc_rs2_tag      (rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'h0; m_busy[i] = 1'b0; m_tag[i] = 4'h0;
    end
  endtask

  task automatic apply(input logic cm, input logic [4:0] ci, input logic [3:0] cr,
                       input logic [31:0] cv, input logic rn, input logic [4:0] r,
                       input logic [3:0] ri, input logic cl, input logic ry,
                       input logic [4:0] s1, input logic [4:0] s2);
    commit = cm; c_idx = ci; c_rob = cr; c_val = cv;
    ren = rn; rd = r; ren_idx = ri; clr_in = cl; rdy_in = ry;
    rs1 = s1; rs2 = s2;
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    apply(1'b0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, s1, s2);
  endtask

  // Expected lookup derived from model state before the edge plus the commit bus.
  task automatic check_port(input string name, input logic [4:0] rs, input logic b,
                            input logic [31:0] v, input logic [3:0] t);
    if (rs == 5'd0) begin
      lit({name, "_x0_busy"}, 32'(b), 32'h0);
      lit({name, "_x0_val"}, v, 32'h0);
      lit({name, "_x0_tag"}, 32'(t), 32'h0);
    end else if (commit && c_idx == rs && m_busy[rs] && m_tag[rs] == c_rob) begin
      lit({name, "_byp_busy"}, 32'(b), 32'h0);
      lit({name, "_byp_val"}, v, c_val);
    end else begin
      lit({name, "_busy"}, 32'(b), 32'(m_busy[rs]));
      if (m_busy[rs]) lit({name, "_tag"}, 32'(t), 32'(m_tag[rs]));
      else            lit({name, "_val"}, v, m_val[rs]);
    end
  endtask

  task automatic check_model();
    #1;
    check_port("rs1", rs1, rs1_busy, rs1_val, rs1_tag);
    check_port("rs2", rs2, rs2_busy, rs2_val, rs2_tag);
  endtask

  task automatic advance();
    logic retire;
    if (rdy_in) begin
      retire = commit && c_idx != 5'd0 && m_busy[c_idx] && m_tag[c_idx] == c_rob;
      if (commit && c_idx != 5'd0) m_val[c_idx] = c_val;
      if (clr_in) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (retire) m_busy[c_idx] = 1'b0;
        if (ren && rd != 5'd0) begin
          m_busy[rd] = 1'b1; m_tag[rd] = ren_idx;
        end
      end
    end
    @(negedge clk_in);
  endtask

  task automatic step(input logic cm, input logic [4:0] ci, input logic [3:0] cr,
                      input logic [31:0] cv, input logic rn, input logic [4:0] r,
                      input logic [3:0] ri, input logic cl, input logic ry);
    apply(cm, ci, cr, cv, rn, r, ri, cl, ry, 5'd0, 5'd0);
    check_model();
    advance();
  endtask

  initial begin
    logic [4:0]  cr;
    logic [3:0]  crob;
    model_reset();
    rst_in = 1'b1;
    idle(5'd0, 5'd0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Reset state then rename x5 -> tag 3
    idle(5'd5, 5'd0); check_model();
    lit("rst_busy", 32'(rs1_busy), 32'h0);
    lit("rst_val", rs1_val, 32'h0);
    lit("rst_tag", 32'(rs1_tag), 32'h0);
    advance();
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd5, 4'd3, 1'b0, 1'b1);
    idle(5'd5, 5'd0); check_model();
    lit("ren_busy", 32'(rs1_busy), 32'h1);
    lit("ren_tag", 32'(rs1_tag), 32'h3);
    advance();

    // Commit bypass in the same cycle, then committed state
    apply(1'b1, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1, 5'd5, 5'd5);
    check_model();
    lit("byp_busy", 32'(rs1_busy), 32'h0);
    lit("byp_val", rs2_val, 32'hDEADBEEF);
    advance();
    idle(5'd5, 5'd0); check_model();
    lit("cmt_busy", 32'(rs1_busy), 32'h0);
    lit("cmt_val", rs1_val, 32'hDEADBEEF);
    advance();

    // Stale commit leaves the newer rename pending
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd5, 4'd3, 1'b0, 1'b1);
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd5, 4'd7, 1'b0, 1'b1);
    step(1'b1, 5'd5, 4'd3, 32'h11, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1);
    idle(5'd5, 5'd0); check_model();
    lit("stale_busy", 32'(rs1_busy), 32'h1);
    lit("stale_tag", 32'(rs1_tag), 32'h7);
    advance();
    step(1'b1, 5'd5, 4'd7, 32'h77, 1'b0, 5'd0, 4'd0, 1'b0, 1'b1);
    idle(5'd5, 5'd0); check_model();
    lit("retire_busy", 32'(rs1_busy), 32'h0);
    lit("retire_val", rs1_val, 32'h77);
    advance();

    // Same-cycle commit and rename of x6: rename wins
    apply(1'b1, 5'd6, 4'd2, 32'h22, 1'b1, 5'd6, 4'd4, 1'b0, 1'b1, 5'd6, 5'd6);
    check_model();
    lit("cr_pre_busy", 32'(rs1_busy), 32'h0);
    advance();
    idle(5'd6, 5'd0); check_model();
    lit("cr_busy", 32'(rs1_busy), 32'h1);
    lit("cr_tag", 32'(rs1_tag), 32'h4);
    advance();

    // Flush with commit to x1 and a dropped rename of x4
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd1, 4'd1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd2, 4'd2, 1'b0, 1'b1);
    step(1'b0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd3, 4'd3, 1'b0, 1'b1);
    step(1'b1, 5'd1, 4'd0, 32'h55, 1'b1, 5'd4, 4'd5, 1'b1, 1'b1);
    idle(5'd1, 5'd2); check_model();
    lit("flush_x1_busy", 32'(rs1_busy), 32'h0);
    lit("flush_x1_val", rs1_val, 32'h55);
    lit("flush_x2_busy", 32'(rs2_busy), 32'h0);
    advance();
    idle(5'd4, 5'd6); check_model();
    lit("flush_x4_busy", 32'(rs1_busy), 32'h0);
    lit("flush_x6_val", rs2_val, 32'h22);
    advance();

    // x0 writes ignored; rdy_in low holds state
    step(1'b1, 5'd0, 4'd9, 32'h99, 1'b1, 5'd0, 4'd9, 1'b0, 1'b1);
    idle(5'd0, 5'd0); check_model();
    lit("x0_val", rs1_val, 32'h0);
    lit("x0_busy", 32'(rs1_busy), 32'h0);
    advance();
    step(1'b1, 5'd8, 4'd0, 32'hAB, 1'b1, 5'd9, 4'd2, 1'b0, 1'b0);
    idle(5'd8, 5'd9); check_model();
    lit("rdy_x8_val", rs1_val, 32'h0);
    lit("rdy_x9_busy", 32'(rs2_busy), 32'h0);
    advance();

    // Randomized traffic over a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      cr   = 5'($urandom_range(0, 7));
      crob = ($urandom_range(0, 1) == 0) ? m_tag[cr] : 4'($urandom_range(0, 15));
      apply($urandom_range(0, 99) < 45, cr, crob, $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      check_model();
      advance();
    end

    // Asynchronous reset between edges clears everything at once
    step(1'b1, 5'd9, 4'd0, 32'hCAFE, 1'b1, 5'd9, 4'd6, 1'b0, 1'b1);
    idle(5'd9, 5'd9);
    #2 rst_in = 1'b1;
    #1;
    lit("arst_busy", 32'(rs1_busy), 32'h0);
    lit("arst_val", rs2_val, 32'h0);
    model_reset();
    @(negedge clk_in);
    apply(1'b1, 5'd9, 4'd0, 32'h1234, 1'b1, 5'd9, 4'd1, 1'b0, 1'b1, 5'd9, 5'd9);
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(5'd9, 5'd0); check_model();
    lit("arst_hold_val", rs1_val, 32'h0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
